branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Parametrised successor to the execute-stage branch resolver: predicts at fetch, resolves and trains at execute.
- Holds a BHT of 2-bit saturating counters, a direct-mapped BTB and a global history register (GHR).
- Supports bimodal or gshare indexing.
- Produces the mispredict and redirect signals that flush fetch/decode, plus performance counters.

Parameters:
- XLEN, 64, PC/target width.
- BHT_DEPTH, 64, BHT entries; power of two.
- BTB_DEPTH, 16, BTB entries; power of two.
- GHR_BITS, 6, history length; must be ≤ log2(BHT_DEPTH).
- MODE, 0, BHT index mode: 0 = bimodal (pc[2 +: log2 BHT_DEPTH]); 1 = gshare (that field XOR zero-extended GHR).
- CNT_W, 32, width of the perf counters.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- pred_valid  in  1  fetch lookup request
- pred_pc  in  XLEN  fetch PC
- pred_taken  out  1  predicted taken
- pred_target  out  XLEN  predicted next PC
- pred_ghr  out  GHR_BITS  GHR snapshot; travels down the pipe with the instruction
- upd_valid  in  1  execute resolves a control instruction this cycle
- upd_pc  in  XLEN  PC of the resolved instruction
- upd_is_jump  in  1  1 = unconditional jump; 0 = conditional branch
- upd_taken  in  1  actual outcome
- upd_target  in  XLEN  actual taken target
- upd_pred_taken  in  1  prediction carried down the pipe
- upd_pred_target  in  XLEN  predicted target carried down the pipe
- upd_ghr  in  GHR_BITS  pred_ghr carried down the pipe
- mispredict  out  1  flush request
- redirect_pc  out  XLEN  correct next PC when mispredict
- perf_branches  out  CNT_W  resolved control instructions
- perf_mispredicts  out  CNT_W  mispredicts

Behaviour:

Reset (resetn low, async):
- All BHT counters = 2'b01 (weakly not-taken).
- All BTB valid bits = 0; GHR = 0; perf counters = 0.
- Outputs derived from this state: pred_taken = 0, pred_target = pred_pc+4, mispredict = 0.
- Reset asserted mid-operation discards all training; no partial writes survive.

Prediction (combinational, 0-cycle latency):
- BTB index = pred_pc[2 +: log2 BTB_DEPTH]; tag = remaining upper PC bits; hit = valid & tag match.
- pred_taken = hit & (entry.jump | BHT[idx][1]).
- pred_target = pred_taken ? entry.target : pred_pc+4.
- pred_ghr = current GHR.
- Outputs are don't-care when pred_valid = 0.

Resolution (combinational):
- mispredict = upd_valid & ((upd_taken != upd_pred_taken) | (upd_taken & upd_target != upd_pred_target)).
- redirect_pc = upd_taken ? upd_target : upd_pc+4.
- Both outputs are 0 when upd_valid = 0.

Training (registered, at the clk edge when upd_valid):
- Conditional branch: BHT entry indexed by upd_pc (gshare uses upd_ghr, not the live GHR) increments if taken, decrements if not taken, saturating at 00 and 11.
- Jumps never touch the BHT.
- BTB: if upd_taken, write {valid=1, tag, target=upd_target, jump=upd_is_jump}, overwriting any alias.
- A not-taken branch leaves the BTB unchanged.

GHR:
- Speculative shift: on pred_valid with a BTB hit on a non-jump entry, GHR <= {GHR[GHR_BITS-2:0], pred_taken}.
- Recovery: on mispredict, GHR <= {upd_ghr[GHR_BITS-2:0], upd_taken} for branches, or upd_ghr for jumps.
- Recovery has priority over a same-cycle speculative shift.

Simultaneous predict and update on the same index:
- The prediction sees the pre-update state.
- The update is visible from the next cycle.

Perf counters:
- perf_branches +1 per upd_valid.
- perf_mispredicts +1 per mispredict.
- Both saturate at all-ones; no wrap.

Test Plan:
- Reset -> lookup pc=0x80000000 gives pred_taken=0, pred_target=0x80000004, perf counters 0.
- Cold branch at 0x80000010, resolved taken to 0x80000100 with pred_taken=0 -> mispredict=1, redirect_pc=0x80000100. Next lookup: counter 10 and BTB hit give pred_taken=1, target 0x80000100.
- Train the same branch taken 3 more times, then not-taken once -> counter 11 then 10, still predicts taken. A second not-taken -> 01, predicts not-taken, BTB entry retained.
- Jump at 0x80000020 to 0x80000400 resolves once -> always predicted taken. Aliasing PC 0x80000060 (BTB_DEPTH=16) taken -> 0x80000020 now misses the BTB.
- MODE=1, GHR_BITS=4: predict with GHR=0101, then mispredict with upd_ghr=0011, upd_taken=1 in the same cycle as a speculative shift -> GHR=0111 next cycle.
- CNT_W=4: 20 resolves with 17 mispredicts -> perf_branches=15, perf_mispredicts=15 (saturated).

Source files
------------

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor
// Description : Fetch-stage branch predictor with execute-stage resolution.
//               A BHT of 2-bit saturating counters (bimodal or gshare index),
//               a direct-mapped BTB and a speculative global history register.
//               Resolution produces the flush/redirect pair and two saturating
//               performance counters.
// Ports       : clk, resetn            - clock, async active-low reset
//               pred_valid/pred_pc     - fetch lookup request
//               pred_taken/target/ghr  - prediction and GHR snapshot
//               upd_*                  - resolved control instruction from EX
//               mispredict/redirect_pc - flush request and correct next PC
//               perf_branches/perf_mispredicts - saturating event counters
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor #(
    parameter int XLEN      = 64,
    parameter int BHT_DEPTH = 64,
    parameter int BTB_DEPTH = 16,
    parameter int GHR_BITS  = 6,
    parameter int MODE      = 0,
    parameter int CNT_W     = 32
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                pred_valid,
    input  logic [XLEN-1:0]     pred_pc,
    output logic                pred_taken,
    output logic [XLEN-1:0]     pred_target,
    output logic [GHR_BITS-1:0] pred_ghr,
    input  logic                upd_valid,
    input  logic [XLEN-1:0]     upd_pc,
    input  logic                upd_is_jump,
    input  logic                upd_taken,
    input  logic [XLEN-1:0]     upd_target,
    input  logic                upd_pred_taken,
    input  logic [XLEN-1:0]     upd_pred_target,
    input  logic [GHR_BITS-1:0] upd_ghr,
    output logic                mispredict,
    output logic [XLEN-1:0]     redirect_pc,
    output logic [CNT_W-1:0]    perf_branches,
    output logic [CNT_W-1:0]    perf_mispredicts
);

    localparam int C_BHT_IDX_W = $clog2(BHT_DEPTH);
    localparam int C_BTB_IDX_W = $clog2(BTB_DEPTH);
    localparam int C_TAG_W     = XLEN - 2 - C_BTB_IDX_W;

    logic [1:0]             r_bht        [BHT_DEPTH];
    logic [BTB_DEPTH-1:0]   r_btb_valid;
    logic [BTB_DEPTH-1:0]   r_btb_jump;
    logic [C_TAG_W-1:0]     r_btb_tag    [BTB_DEPTH];
    logic [XLEN-1:0]        r_btb_target [BTB_DEPTH];
    logic [GHR_BITS-1:0]    r_ghr;
    logic [CNT_W-1:0]       r_perf_br;
    logic [CNT_W-1:0]       r_perf_mis;

    logic [C_BHT_IDX_W-1:0] w_pred_bht_idx;
    logic [C_BHT_IDX_W-1:0] w_upd_bht_idx;
    logic [C_BTB_IDX_W-1:0] w_pred_btb_idx;
    logic [C_BTB_IDX_W-1:0] w_upd_btb_idx;
    logic [C_TAG_W-1:0]     w_pred_tag;
    logic                   w_hit;
    logic                   w_pred_jump;
    logic                   w_pred_taken;
    logic                   w_mispredict;

    // The update side indexes with the history captured at predict time so
    // the counter trained is the one that produced the prediction.
    generate
        if (MODE == 1) begin : g_gshare
            assign w_pred_bht_idx = pred_pc[2 +: C_BHT_IDX_W] ^ C_BHT_IDX_W'(r_ghr);
            assign w_upd_bht_idx  = upd_pc[2 +: C_BHT_IDX_W] ^ C_BHT_IDX_W'(upd_ghr);
        end else begin : g_bimodal
            assign w_pred_bht_idx = pred_pc[2 +: C_BHT_IDX_W];
            assign w_upd_bht_idx  = upd_pc[2 +: C_BHT_IDX_W];
        end
    endgenerate

    // ---------------- Prediction ----------------
    assign w_pred_btb_idx = pred_pc[2 +: C_BTB_IDX_W];
    assign w_upd_btb_idx  = upd_pc[2 +: C_BTB_IDX_W];
    assign w_pred_tag     = pred_pc[XLEN-1 -: C_TAG_W];
    assign w_hit          = r_btb_valid[w_pred_btb_idx] &&
                            (r_btb_tag[w_pred_btb_idx] == w_pred_tag);
    assign w_pred_jump    = r_btb_jump[w_pred_btb_idx];
    assign w_pred_taken   = w_hit && (w_pred_jump || r_bht[w_pred_bht_idx][1]);

    assign pred_taken  = w_pred_taken;
    assign pred_target = w_pred_taken ? r_btb_target[w_pred_btb_idx] : pred_pc + XLEN'(4);
    assign pred_ghr    = r_ghr;

    // ---------------- Resolution ----------------
    assign w_mispredict = upd_valid &&
                          ((upd_taken != upd_pred_taken) ||
                           (upd_taken && (upd_target != upd_pred_target)));
    assign mispredict   = w_mispredict;
    assign redirect_pc  = upd_valid ? (upd_taken ? upd_target : upd_pc + XLEN'(4)) : '0;

    assign perf_branches    = r_perf_br;
    assign perf_mispredicts = r_perf_mis;

    // ---------------- BHT training ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                r_bht[i] <= 2'b01;
            end
        end else if (upd_valid && !upd_is_jump) begin
            if (upd_taken) begin
                if (r_bht[w_upd_bht_idx] != 2'b11) begin
                    r_bht[w_upd_bht_idx] <= r_bht[w_upd_bht_idx] + 2'd1;
                end
            end else if (r_bht[w_upd_bht_idx] != 2'b00) begin
                r_bht[w_upd_bht_idx] <= r_bht[w_upd_bht_idx] - 2'd1;
            end
        end
    end

    // ---------------- BTB ----------------
    // Only the valid bits need reset; payload is ignored while invalid.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_btb_valid <= '0;
        end else if (upd_valid && upd_taken) begin
            r_btb_valid[w_upd_btb_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (upd_valid && upd_taken) begin
            r_btb_tag[w_upd_btb_idx]    <= upd_pc[XLEN-1 -: C_TAG_W];
            r_btb_target[w_upd_btb_idx] <= upd_target;
            r_btb_jump[w_upd_btb_idx]   <= upd_is_jump;
        end
    end

    // ---------------- GHR ----------------
    // Recovery from a mispredict outranks any speculative shift that the
    // (now wrong-path) fetch lookup would apply in the same cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ghr <= '0;
        end else if (w_mispredict) begin
            r_ghr <= upd_is_jump ? upd_ghr : {upd_ghr[GHR_BITS-2:0], upd_taken};
        end else if (pred_valid && w_hit && !w_pred_jump) begin
            r_ghr <= {r_ghr[GHR_BITS-2:0], w_pred_taken};
        end
    end

    // ---------------- Performance counters ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_perf_br  <= '0;
            r_perf_mis <= '0;
        end else begin
            if (upd_valid && (r_perf_br != '1)) begin
                r_perf_br <= r_perf_br + CNT_W'(1);
            end
            if (w_mispredict && (r_perf_mis != '1)) begin
                r_perf_mis <= r_perf_mis + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_predictor
// Description : Self-checking bench. Two predictors share one stimulus
//               stream: a bimodal instance (GHR 6 bits, 4-bit counters) and
//               a gshare instance (GHR 4 bits, 32-bit counters). A behavioural
//               model tracks both and is compared every cycle; directed
//               literal checks pin the model to hand-worked values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor;

    logic        clk             = 1'b0;
    logic        resetn          = 1'b0;
    logic        pred_valid      = 1'b0;
    logic [63:0] pred_pc         = '0;
    logic        upd_valid       = 1'b0;
    logic [63:0] upd_pc          = '0;
    logic        upd_is_jump     = 1'b0;
    logic        upd_taken       = 1'b0;
    logic [63:0] upd_target      = '0;
    logic        upd_pred_taken  = 1'b0;
    logic [63:0] upd_pred_target = '0;
    logic [5:0]  upd_ghr         = '0;

    logic        pred_taken0, pred_taken1;
    logic [63:0] pred_target0, pred_target1;
    logic [5:0]  pred_ghr0;
    logic [3:0]  pred_ghr1;
    logic        mispredict0, mispredict1;
    logic [63:0] redirect0, redirect1;
    logic [3:0]  pb0, pm0;
    logic [31:0] pb1, pm1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_predictor #(
        .XLEN(64), .BHT_DEPTH(64), .BTB_DEPTH(16), .GHR_BITS(6), .MODE(0), .CNT_W(4)
    ) u_bim (
        .clk(clk), .resetn(resetn),
        .pred_valid(pred_valid), .pred_pc(pred_pc),
        .pred_taken(pred_taken0), .pred_target(pred_target0), .pred_ghr(pred_ghr0),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_jump(upd_is_jump),
        .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
        .upd_ghr(upd_ghr),
        .mispredict(mispredict0), .redirect_pc(redirect0),
        .perf_branches(pb0), .perf_mispredicts(pm0)
    );

    branch_predictor #(
        .XLEN(64), .BHT_DEPTH(64), .BTB_DEPTH(16), .GHR_BITS(4), .MODE(1), .CNT_W(32)
    ) u_gsh (
        .clk(clk), .resetn(resetn),
        .pred_valid(pred_valid), .pred_pc(pred_pc),
        .pred_taken(pred_taken1), .pred_target(pred_target1), .pred_ghr(pred_ghr1),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_jump(upd_is_jump),
        .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
        .upd_ghr(upd_ghr[3:0]),
        .mispredict(mispredict1), .redirect_pc(redirect1),
        .perf_branches(pb1), .perf_mispredicts(pm1)
    );

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- Behavioural model (instance 0 = bimodal, 1 = gshare) ----
    int              m_bht  [2][64];   // counter value 0..3
    bit              m_bv   [2][16];
    logic [63:0]     m_btag [2][16];   // pc / 64
    logic [63:0]     m_btgt [2][16];
    bit              m_bj   [2][16];
    int              m_ghr  [2];
    longint unsigned m_pb   [2];
    longint unsigned m_pm   [2];

    function automatic int gmask(input int k);
        return (k == 0) ? 63 : 15;
    endfunction

    function automatic longint unsigned cmax(input int k);
        return (k == 0) ? 64'd15 : 64'hFFFF_FFFF;
    endfunction

    function automatic int bidx(input int k, input logic [63:0] pc, input int g);
        int i;
        i = int'((pc / 4) % 64);
        if (k == 1) i = i ^ g;
        return i;
    endfunction

    function automatic int tslot(input logic [63:0] pc);
        return int'((pc / 4) % 16);
    endfunction

    function automatic bit btb_hit(input int k, input logic [63:0] pc);
        return m_bv[k][tslot(pc)] && (m_btag[k][tslot(pc)] == pc / 64);
    endfunction

    function automatic bit mdl_taken(input int k, input logic [63:0] pc);
        return btb_hit(k, pc) &&
               (m_bj[k][tslot(pc)] || (m_bht[k][bidx(k, pc, m_ghr[k])] >= 2));
    endfunction

    function automatic logic [63:0] mdl_target(input int k, input logic [63:0] pc);
        return mdl_taken(k, pc) ? m_btgt[k][tslot(pc)] : pc + 64'd4;
    endfunction

    function automatic bit mdl_mis();
        return upd_valid && ((upd_taken != upd_pred_taken) ||
                             (upd_taken && (upd_target != upd_pred_target)));
    endfunction

    function automatic logic [63:0] mdl_redirect();
        if (!upd_valid) return 64'd0;
        return upd_taken ? upd_target : upd_pc + 64'd4;
    endfunction

    task automatic mdl_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 64; i++) m_bht[k][i] = 1;
            for (int i = 0; i < 16; i++) m_bv[k][i] = 1'b0;
            m_ghr[k] = 0;
            m_pb[k]  = 0;
            m_pm[k]  = 0;
        end
    endtask

    task automatic mdl_step(input int k);
        bit tk;
        bit mis;
        int ug;
        int bi;
        int t;
        tk  = mdl_taken(k, pred_pc);
        mis = mdl_mis();
        ug  = int'(upd_ghr) & gmask(k);
        if (mis)
            m_ghr[k] = upd_is_jump ? ug : (((ug * 2) + int'(upd_taken)) & gmask(k));
        else if (pred_valid && btb_hit(k, pred_pc) && !m_bj[k][tslot(pred_pc)])
            m_ghr[k] = ((m_ghr[k] * 2) + int'(tk)) & gmask(k);
        if (upd_valid) begin
            if (!upd_is_jump) begin
                bi = bidx(k, upd_pc, ug);
                if (upd_taken) m_bht[k][bi] = (m_bht[k][bi] == 3) ? 3 : m_bht[k][bi] + 1;
                else           m_bht[k][bi] = (m_bht[k][bi] == 0) ? 0 : m_bht[k][bi] - 1;
            end
            if (upd_taken) begin
                t = tslot(upd_pc);
                m_bv[k][t]   = 1'b1;
                m_btag[k][t] = upd_pc / 64;
                m_btgt[k][t] = upd_target;
                m_bj[k][t]   = upd_is_jump;
            end
            if (m_pb[k] < cmax(k)) m_pb[k]++;
            if (mis && (m_pm[k] < cmax(k))) m_pm[k]++;
        end
    endtask

    always @(posedge clk) begin
        if (!resetn) mdl_reset();
        else for (int k = 0; k < 2; k++) mdl_step(k);
    end

    // ---------------- Per-cycle compare ----------------
    always @(negedge clk) begin
        if (resetn) begin
            if (pred_valid) begin
                check64("bim pred_taken",  64'(pred_taken0),  64'(mdl_taken(0, pred_pc)));
                check64("bim pred_target", pred_target0,      mdl_target(0, pred_pc));
                check64("bim pred_ghr",    64'(pred_ghr0),    64'(m_ghr[0]));
                check64("gsh pred_taken",  64'(pred_taken1),  64'(mdl_taken(1, pred_pc)));
                check64("gsh pred_target", pred_target1,      mdl_target(1, pred_pc));
                check64("gsh pred_ghr",    64'(pred_ghr1),    64'(m_ghr[1]));
            end
            check64("bim mispredict",  64'(mispredict0), 64'(mdl_mis()));
            check64("bim redirect_pc", redirect0,        mdl_redirect());
            check64("gsh mispredict",  64'(mispredict1), 64'(mdl_mis()));
            check64("gsh redirect_pc", redirect1,        mdl_redirect());
            check64("bim perf_branches",    64'(pb0), m_pb[0]);
            check64("bim perf_mispredicts", 64'(pm0), m_pm[0]);
            check64("gsh perf_branches",    64'(pb1), m_pb[1]);
            check64("gsh perf_mispredicts", 64'(pm1), m_pm[1]);
        end
    end

    // ---------------- Stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        pred_valid = 1'b0;
        upd_valid  = 1'b0;
    endtask

    task automatic predict(input logic [63:0] pc);
        pred_valid = 1'b1;
        pred_pc    = pc;
    endtask

    task automatic update(input logic [63:0] pc, input bit jmp, input bit tkn,
                          input logic [63:0] tgt, input bit ptk, input logic [63:0] ptgt,
                          input logic [5:0] g);
        upd_valid       = 1'b1;
        upd_pc          = pc;
        upd_is_jump     = jmp;
        upd_taken       = tkn;
        upd_target      = tgt;
        upd_pred_taken  = ptk;
        upd_pred_target = ptgt;
        upd_ghr         = g;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        mdl_reset();
        repeat (3) tick();
        resetn = 1'b1;

        // Reset state
        predict(64'h8000_0000);
        @(negedge clk);
        check64("reset pred_taken",  64'(pred_taken0), 64'd0);
        check64("reset pred_target", pred_target0,     64'h8000_0004);
        check64("reset perf_br",     64'(pb0),         64'd0);
        check64("reset perf_mis",    64'(pm0),         64'd0);
        tick();

        // Cold branch resolved taken
        update(64'h8000_0010, 0, 1, 64'h8000_0100, 0, 64'h8000_0014, 6'd0);
        @(negedge clk);
        check64("cold mispredict", 64'(mispredict0), 64'd1);
        check64("cold redirect",   redirect0,        64'h8000_0100);
        tick();
        predict(64'h8000_0010);
        @(negedge clk);
        check64("trained pred_taken",  64'(pred_taken0), 64'd1);
        check64("trained pred_target", pred_target0,     64'h8000_0100);
        tick();

        // Three more taken resolves; the middle one carries a wrong target
        update(64'h8000_0010, 0, 1, 64'h8000_0100, 1, 64'h8000_0100, 6'd0);
        @(negedge clk);
        check64("correct no mispredict", 64'(mispredict0), 64'd0);
        tick();
        update(64'h8000_0010, 0, 1, 64'h8000_0100, 1, 64'h8000_0104, 6'd0);
        @(negedge clk);
        check64("wrong target mispredict", 64'(mispredict0), 64'd1);
        check64("wrong target redirect",   redirect0,        64'h8000_0100);
        tick();
        update(64'h8000_0010, 0, 1, 64'h8000_0100, 1, 64'h8000_0100, 6'd0);
        tick();

        // First not-taken: 11 -> 10, still taken
        update(64'h8000_0010, 0, 0, 64'h8000_0100, 1, 64'h8000_0100, 6'd0);
        @(negedge clk);
        check64("nt1 mispredict", 64'(mispredict0), 64'd1);
        check64("nt1 redirect",   redirect0,        64'h8000_0014);
        tick();
        predict(64'h8000_0010);
        @(negedge clk);
        check64("cnt10 pred_taken", 64'(pred_taken0), 64'd1);
        tick();

        // Second not-taken with same-cycle lookup: lookup sees pre-update 10
        predict(64'h8000_0010);
        update(64'h8000_0010, 0, 0, 64'h8000_0100, 1, 64'h8000_0100, 6'd1);
        @(negedge clk);
        check64("same-cycle pre-update", 64'(pred_taken0), 64'd1);
        tick();
        predict(64'h8000_0010);
        @(negedge clk);
        check64("cnt01 pred_taken",  64'(pred_taken0), 64'd0);
        check64("cnt01 pred_target", pred_target0,     64'h8000_0014);
        check64("recovered ghr",     64'(pred_ghr0),   64'd2);
        tick();
        predict(64'h8000_0000);
        @(negedge clk);
        check64("btb retained ghr shift", 64'(pred_ghr0), 64'd4);
        tick();

        // Jump, then aliasing branch evicts it
        update(64'h8000_0020, 1, 1, 64'h8000_0400, 0, 64'h8000_0024, 6'd0);
        @(negedge clk);
        check64("jump mispredict", 64'(mispredict0), 64'd1);
        tick();
        predict(64'h8000_0020);
        @(negedge clk);
        check64("jump pred_taken",  64'(pred_taken0), 64'd1);
        check64("jump pred_target", pred_target0,     64'h8000_0400);
        tick();
        update(64'h8000_0060, 0, 1, 64'h8000_0800, 0, 64'h8000_0064, 6'd0);
        tick();
        predict(64'h8000_0020);
        @(negedge clk);
        check64("alias evict taken",  64'(pred_taken0), 64'd0);
        check64("alias evict target", pred_target0,     64'h8000_0024);
        tick();

        // Asynchronous reset in mid-operation discards training immediately
        resetn = 1'b0;
        predict(64'h8000_0060);
        @(negedge clk);
        check64("async reset pred_taken", 64'(pred_taken0), 64'd0);
        check64("async reset perf_br",    64'(pb0),         64'd0);
        tick();
        resetn = 1'b1;
        predict(64'h8000_0060);
        @(negedge clk);
        check64("post reset pred_target", pred_target0, 64'h8000_0064);
        tick();

        // GHR recovery beats speculative shift (gshare, 4-bit GHR)
        update(64'h8000_0010, 0, 1, 64'h8000_0100, 0, 64'h8000_0014, 6'd0);
        tick();
        update(64'h8000_0020, 1, 1, 64'h8000_0400, 0, 64'h8000_0024, 6'b000101);
        tick();
        predict(64'h8000_0010);
        update(64'h8000_0030, 0, 1, 64'h8000_0200, 0, 64'h8000_0034, 6'b000011);
        @(negedge clk);
        check64("gsh ghr before", 64'(pred_ghr1), 64'h5);
        tick();
        predict(64'h8000_0000);
        @(negedge clk);
        check64("gsh ghr recovered", 64'(pred_ghr1), 64'h7);
        check64("bim ghr recovered", 64'(pred_ghr0), 64'h7);
        tick();

        // Perf counter saturation: 20 resolves, 17 mispredicts
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            update(64'h8000_1000, 0, 0, 64'h8000_2000, (i < 17), 64'h8000_2000, 6'd0);
            tick();
        end
        @(negedge clk);
        check64("sat perf_br",  64'(pb0), 64'd15);
        check64("sat perf_mis", 64'(pm0), 64'd15);
        check64("wide perf_br",  64'(pb1), 64'd20);
        check64("wide perf_mis", 64'(pm1), 64'd17);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
